dmem_rmw_ctrl: RTL and testbench

- Memory-side responder for the core's load/store path.
- Accepts one LSU request at a time: byte address, funct3 and raw store data.
- Drives a single-port synchronous SRAM with no byte enables and 1-cycle read latency.
- Loads return the raw, unaligned-extracted word for the load unit to slice. Sub-word stores run as read-modify-write; full-width stores are written directly.

---
 rtl/dmem_rmw_ctrl_pkg.sv | 42 ++++
 rtl/dmem_mask_gen.sv | 55 +++++
 rtl/dmem_rmw_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared encodings for the data-memory RMW controller: funct3 codes, FSM states,
// access sizes and XLEN-derived helpers.
package dmem_rmw_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Index of the highest byte-offset bit within one memory word.
    function automatic int msb_for(input int xlen);
        return (xlen == 64) ? 2 : 1;
    endfunction

    function automatic logic is_full_store(input logic [2:0] f3, input int xlen);
        return (xlen == 64) ? (f3 == F3_SD) : (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/dmem_mask_gen.sv
// Byte-lane mask/shift and legality decode for one access; purely combinational, 0 cycles.
// No handshake: outputs follow funct3/write/addr_lo directly.
module dmem_mask_gen
    import dmem_rmw_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MSB  = 1
) (
    input  logic [2:0]      funct3,
    input  logic            write,
    input  logic [MSB:0]    addr_lo,
    output logic [XLEN-1:0] mask,
    output logic [MSB+3:0]  shift,
    output logic            misaligned,
    output logic            illegal
);

    size_e           size;
    logic [XLEN-1:0] base;

    always_comb begin
        size       = size_e'(funct3[1:0]);
        shift      = {addr_lo, 3'b000};
        base       = '1;
        misaligned = 1'b0;
        illegal    = 1'b0;

        case (size)
            SZ_B: base = XLEN'(8'hFF);
            SZ_H: begin
                base       = XLEN'(16'hFFFF);
                misaligned = addr_lo[0];
            end
            SZ_W: begin
                base       = XLEN'(32'hFFFF_FFFF);
                misaligned = |addr_lo[1:0];
            end
            default: begin
                base       = '1;
                misaligned = |addr_lo;
            end
        endcase

        mask = base << shift;

        // Stores have no unsigned variants; doubleword forms only exist on RV64.
        if (write) begin
            illegal = funct3[2] || ((size == SZ_D) && (XLEN != 64));
        end else begin
            illegal = (funct3 == 3'b111) ||
                      (((size == SZ_D) || (funct3 == F3_LWU)) && (XLEN != 64));
        end
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// LSU-to-SRAM responder; accept-to-rsp latency: load 3, sub-word store 4 (RMW), full store 2, error 1.
// One request in flight; rsp_ready low parks in RESP and req_ready stays low until the handshake.
module dmem_rmw_ctrl
    import dmem_rmw_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int MSB  = msb_for(XLEN);
    localparam int KEEP = MSB + MEM_AW + 1;

    state_e          state_q, state_d;
    logic [KEEP-1:0] addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    // Address bits above the SRAM range wrap and are never stored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:KEEP];

    logic            idle;
    logic [2:0]      dec_funct3;
    logic            dec_write;
    logic [MSB:0]    dec_addr_lo;
    logic [XLEN-1:0] mask;
    logic [MSB+3:0]  shift;
    logic            misaligned;
    logic            illegal;
    logic            dec_err;
    logic [XLEN-1:0] merged;

    // The decoder sees the live request while idle and the captured one afterwards.
    assign idle        = (state_q == ST_IDLE);
    assign dec_funct3  = idle ? req_funct3     : funct3_q;
    assign dec_write   = idle ? req_write      : write_q;
    assign dec_addr_lo = idle ? req_addr[MSB:0] : addr_q[MSB:0];

    dmem_mask_gen #(
        .XLEN (XLEN),
        .MSB  (MSB)
    ) u_mask_gen (
        .funct3     (dec_funct3),
        .write      (dec_write),
        .addr_lo    (dec_addr_lo),
        .mask       (mask),
        .shift      (shift),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign dec_err = illegal || misaligned;
    assign merged  = (buf_q & ~mask) | ((wdata_q << shift) & mask);

    assign mem_addr  = addr_q[KEEP-1:MSB+1];
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d      = req_addr[KEEP-1:0];
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = dec_err;
                    if (dec_err) begin
                        state_d = ST_RESP;
                    end else if (req_write && is_full_store(req_funct3, XLEN)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_en  = 1'b1;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                buf_d = mem_rdata;
                if (write_q) begin
                    state_d = ST_WR;
                end else begin
                    rsp_rdata_d = mem_rdata;
                    state_d     = ST_RESP;
                end
            end
            ST_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = is_full_store(funct3_q, XLEN) ? wdata_q : merged;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl at XLEN=32 with a behavioural 1-cycle-read SRAM.
module tb_dmem_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(
        .XLEN   (32),
        .ADDR_W (32),
        .MEM_AW (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // SRAM model with a bench-side preload port and access counters.
    logic [31:0] mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [15:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                n_wr    <= n_wr + 1;
                last_wa <= mem_addr;
                last_wd <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
                n_rd      <= n_rd + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issue one request from IDLE, measure accept-to-rsp_valid cycles, then complete the handshake.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] f3,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic er);
        req_addr   = a;
        req_write  = w;
        req_funct3 = f3;
        req_wdata  = wd;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        tick();
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          rd0;
        int          wr0;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_funct3 = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_mem_en",    64'(mem_en),    64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        tick();

        // LW aligned
        preload(16'h0040, 32'h1122_3344);
        rd0 = n_rd; wr0 = n_wr;
        do_req(32'h100, 1'b0, 3'b010, 32'h0, lat, rd, er);
        check("lw_lat",   64'(lat), 64'd3);
        check("lw_rdata", 64'(rd),  64'h1122_3344);
        check("lw_err",   64'(er),  64'd0);
        check("lw_reads", 64'(n_rd - rd0), 64'd1);
        check("lw_writes", 64'(n_wr - wr0), 64'd0);
        check("lw_rsp_drop", 64'(rsp_valid), 64'd0);

        // SB into byte 1
        rd0 = n_rd; wr0 = n_wr;
        do_req(32'h101, 1'b1, 3'b000, 32'h0000_00AB, lat, rd, er);
        check("sb_lat",    64'(lat), 64'd4);
        check("sb_rdata",  64'(rd),  64'd0);
        check("sb_err",    64'(er),  64'd0);
        check("sb_reads",  64'(n_rd - rd0), 64'd1);
        check("sb_writes", 64'(n_wr - wr0), 64'd1);
        check("sb_waddr",  64'(last_wa), 64'h40);
        check("sb_wdata",  64'(last_wd), 64'h1122_AB44);

        // SH into upper half
        preload(16'h0040, 32'h1122_3344);
        do_req(32'h102, 1'b1, 3'b001, 32'h0000_BEEF, lat, rd, er);
        check("sh_lat",   64'(lat), 64'd4);
        check("sh_wdata", 64'(last_wd), 64'hBEEF_3344);

        // SW full width: direct write
        rd0 = n_rd; wr0 = n_wr;
        do_req(32'h104, 1'b1, 3'b010, 32'hCAFE_F00D, lat, rd, er);
        check("sw_lat",    64'(lat), 64'd2);
        check("sw_reads",  64'(n_rd - rd0), 64'd0);
        check("sw_writes", 64'(n_wr - wr0), 64'd1);
        check("sw_waddr",  64'(last_wa), 64'h41);
        check("sw_wdata",  64'(last_wd), 64'hCAFE_F00D);

        // Error cases: misaligned LW, LD on RV32, store funct3 111, misaligned LH
        rd0 = n_rd; wr0 = n_wr;
        do_req(32'h102, 1'b0, 3'b010, 32'h0, lat, rd, er);
        check("lw_mis_lat",   64'(lat), 64'd1);
        check("lw_mis_err",   64'(er),  64'd1);
        check("lw_mis_rdata", 64'(rd),  64'd0);
        check("lw_mis_noacc", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd0);
        do_req(32'h100, 1'b0, 3'b011, 32'h0, lat, rd, er);
        check("ld_rv32_err", 64'(er), 64'd1);
        do_req(32'h100, 1'b1, 3'b111, 32'h0, lat, rd, er);
        check("st_f3_7_err", 64'(er), 64'd1);
        do_req(32'h101, 1'b0, 3'b001, 32'h0, lat, rd, er);
        check("lh_mis_err", 64'(er), 64'd1);
        do_req(32'h100, 1'b0, 3'b110, 32'h0, lat, rd, er);
        check("lwu_rv32_err", 64'(er), 64'd1);
        check("err_noacc", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd0);

        // LBU at odd offset returns the whole word; high address bits wrap
        do_req(32'h103, 1'b0, 3'b100, 32'h0, lat, rd, er);
        check("lbu_rdata", 64'(rd), 64'hBEEF_3344);
        check("lbu_err",   64'(er), 64'd0);
        do_req(32'h0004_0100, 1'b0, 3'b010, 32'h0, lat, rd, er);
        check("wrap_rdata", 64'(rd), 64'hBEEF_3344);

        // Backpressure: response held while rsp_ready is low
        rsp_ready  = 1'b0;
        req_addr   = 32'h104;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_lat", 64'(lat), 64'd3);
        rd0 = n_rd;
        req_addr  = 32'h100;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        check("bp_no_access", 64'(n_rd - rd0), 64'd0);
        rsp_ready = 1'b1;
        tick();
        check("bp_rel_valid", 64'(rsp_valid), 64'd0);
        check("bp_rel_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_next_lat",   64'(lat), 64'd3);
        check("bp_next_rdata", 64'(rsp_rdata), 64'hBEEF_3344);
        tick();

        // Reset during CAP of an SB aborts it
        wr0 = n_wr;
        req_addr   = 32'h100;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_wdata  = 32'h55;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_mem_we",   64'(mem_we),    64'd0);
        check("abort_rsp_vld",  64'(rsp_valid), 64'd0);
        tick();
        check("abort_req_ready", 64'(req_ready), 64'd1);
        repeat (3) begin
            check("abort_rsp_quiet", 64'(rsp_valid), 64'd0);
            tick();
        end
        check("abort_no_write", 64'(n_wr - wr0), 64'd0);
        do_req(32'h100, 1'b0, 3'b010, 32'h0, lat, rd, er);
        check("abort_word_kept", 64'(rd), 64'hBEEF_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
